// File: rtl/exception_vector_loader_if.sv
// exception_vector_loader_if: exception request, vector memory read and PC/EPC update signals
interface exception_vector_loader_if;
  logic exc_req;
  logic [1:0] exc_code;
  logic [31:0] pc_in;
  logic [31:0] mem_rdata;
  logic mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] pc_out;
  logic pc_we;
  logic [31:0] epc_out;
  logic epc_we;
  logic [1:0] cause_out;
  logic busy;
  logic drop;
  modport master (
    output exc_req, exc_code, pc_in, mem_rdata,
    input mem_rd, mem_addr, pc_out, pc_we, epc_out, epc_we, cause_out, busy, drop
  );
  modport slave (
    input exc_req, exc_code, pc_in, mem_rdata,
    output mem_rd, mem_addr, pc_out, pc_we, epc_out, epc_we, cause_out, busy, drop
  );
endinterface

// File: rtl/exception_vector_loader.sv
// exception_vector_loader: fetches the handler byte from the vector table and issues one PC/EPC write per exception
module exception_vector_loader #(
  parameter int MEM_LATENCY = 1
) (
  input logic clk,
  input logic reset,
  exception_vector_loader_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [1:0] cause;
  logic [31:0] epc, pc_q, epc_q;
  logic drop_q, valid_req, last_wait, rdata_unused;
  assign valid_req = bus.exc_req && (bus.exc_code != 2'b00);
  assign last_wait = (state == WAIT) && (cnt == 4'd1);
  assign rdata_unused = ^bus.mem_rdata[31:8];
  always_comb begin
    state_nx = state;
    if (state == IDLE && valid_req) state_nx = ISSUE;
    if (state == ISSUE) state_nx = WAIT;
    if (last_wait) state_nx = DONE;
    if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cause <= '0;
      epc <= '0;
      pc_q <= '0;
      epc_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state <= state_nx;
      drop_q <= valid_req && (state != IDLE);
      if (state == IDLE && valid_req) begin
        cause <= bus.exc_code;
        epc <= bus.pc_in - 32'd4;
      end
      if (state == ISSUE) cnt <= 4'(MEM_LATENCY);
      else if (state == WAIT) cnt <= cnt - 4'd1;
      if (last_wait) begin
        pc_q <= {24'h0, bus.mem_rdata[7:0]};
        epc_q <= epc;
      end
    end
  end
  // vector table sits at 0xFD..0xFF, indexed directly by the cause code
  assign bus.mem_rd = (state == ISSUE);
  assign bus.mem_addr = (state == ISSUE || state == WAIT) ? {24'h0, 6'h3F, cause} : 32'h0;
  assign bus.pc_we = (state == DONE);
  assign bus.epc_we = (state == DONE);
  assign bus.busy = (state != IDLE);
  assign bus.drop = drop_q;
  assign bus.pc_out = pc_q;
  assign bus.epc_out = epc_q;
  assign bus.cause_out = cause;
endmodule

// File: doc/exception_vector_loader.md
EXCEPTION_VECTOR_LOADER -- requirements
Module: exception_vector_loader

Interface
REQ-001 Parameter: MEM_LATENCY, default 1, cycles from the mem_rd pulse until mem_rdata is valid; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 exc_req  input  1  exception request, sampled on the rising edge.
REQ-005 exc_code  input  2  cause: 01 invalid opcode, 10 overflow, 11 divide by zero, 00 none.
REQ-006 pc_in  input  32  PC value at request (already incremented past the faulting instruction).
REQ-007 mem_rdata  input  32  memory read data; the handler byte is bits [7:0].
REQ-008 mem_rd  output  1  one-cycle memory read strobe.
REQ-009 mem_addr  output  32  vector address driven toward memory.
REQ-010 pc_out  output  32  handler address, zero-extended from the vector byte.
REQ-011 pc_we  output  1  one-cycle PC write strobe.
REQ-012 epc_out  output  32  faulting-instruction address.
REQ-013 epc_we  output  1  one-cycle EPC write strobe, coincident with pc_we.
REQ-014 cause_out  output  2  latched exc_code of the request being served.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 drop  output  1  one-cycle pulse when a request is discarded.

Function
REQ-017 The block SHALL implement four states: IDLE, ISSUE, WAIT and DONE.
REQ-018 In IDLE, an edge with exc_req=1 and exc_code!=00 SHALL latch cause, latch epc = pc_in - 4 (mod 2^32) and move to ISSUE.
REQ-019 In IDLE, exc_req=1 with exc_code=00 SHALL be ignored: remain in IDLE, no drop pulse.
REQ-020 The vector address SHALL be 253 (0x000000FD) for code 01, 254 (0xFE) for code 10 and 255 (0xFF) for code 11.
REQ-021 ISSUE SHALL last one cycle with mem_rd=1 and mem_addr=vector, load a 4-bit counter with MEM_LATENCY, and then go to WAIT.
REQ-022 WAIT SHALL last exactly MEM_LATENCY cycles: mem_rd=0, mem_addr held at the vector, counter decremented each cycle.
REQ-023 On the edge ending the last WAIT cycle, the block SHALL capture mem_rdata[7:0] and go to DONE; mem_rdata is not sampled at any other time.
REQ-024 DONE SHALL last one cycle with pc_we=1, epc_we=1, pc_out={24'b0, byte} and epc_out=latched epc, then return to IDLE.
REQ-025 With the request sampled at edge E, pc_we SHALL be high during cycle E+MEM_LATENCY+2 (e.g. the third cycle after E for latency 1).
REQ-026 pc_out, epc_out and cause_out SHALL hold their last values after DONE until the next capture.
REQ-027 mem_addr SHALL be 0 in IDLE and DONE.
REQ-028 Any exc_req=1 with exc_code!=00 sampled while busy=1 SHALL be discarded, with drop pulsed high the following cycle and no effect on the operation in progress.
REQ-029 A request sampled on the same edge that leaves DONE for IDLE SHALL be treated as arriving while busy (discarded, drop pulsed); a new request is only accepted from IDLE.
REQ-030 pc_in=0 SHALL yield epc_out=0xFFFFFFFC (wrap-around, no flag).
REQ-031 mem_rdata bits [31:8] SHALL NOT affect any output.

Reset
REQ-032 Asserting reset SHALL immediately force IDLE and clear all outputs to 0 (mem_rd, mem_addr, pc_out, pc_we, epc_out, epc_we, cause_out, busy, drop) plus the counter and latched state.
REQ-033 Reset asserted mid-operation SHALL abort it with no pc_we or epc_we pulse, either during reset or after release.
REQ-034 On the first edge after reset deasserts, the block SHALL accept a new request normally.

Verification
REQ-035 Overflow, latency 1: code=10, pc_in=0x40, mem_rdata[7:0]=0x80 -> mem_rd at 0xFE for one cycle; pc_we and epc_we high on the third cycle; pc_out=0x00000080, epc_out=0x3C, cause_out=10.
REQ-036 Codes 01 and 11 with MEM_LATENCY=3 -> mem_addr 0xFD and 0xFF respectively; pc_we high on the fifth cycle after the request; only the data present in the last WAIT cycle is used.
REQ-037 A second request (code 11) one cycle after an accepted code-01 request -> drop pulses once; the outputs reflect code 01 only; a request issued after pc_we is served normally.
REQ-038 pc_in=0, code=01 -> epc_out=0xFFFFFFFC; mem_rdata=0xFFFFFF12 -> pc_out=0x00000012.
REQ-039 Reset asserted during WAIT -> all outputs 0 asynchronously; no pc_we afterwards; the next request completes with correct timing.
REQ-040 exc_req=1 with code=00 in IDLE -> busy stays 0, no mem_rd, no drop.
